// File: rtl/fairy_muldiv_ctrl_if.sv
// Execute-stage interface of the fairy HI/LO multiply/divide sequencer.
// Request, flush and MTHI/MTLO signals come in; busy, done and HI/LO go out.
interface fairy_muldiv_ctrl_if;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs_i;
    logic [31:0] rt_i;
    logic        cancel_i;
    logic        mthi_i;
    logic        mtlo_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output start_i, op_i, rs_i, rt_i, cancel_i, mthi_i, mtlo_i, wdata_i,
        input  busy_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, rs_i, rt_i, cancel_i, mthi_i, mtlo_i, wdata_i,
        output busy_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/fairy_muldiv_ctrl.sv
// HI/LO owner: registered multiplier plus 32-step restoring divider.
// Optional MULDIV_BUSY_CNT_EN adds a saturating busy-cycle counter output.
//
// state    | meaning
// IDLE     | HI/LO writable by MTHI/MTLO, accepting start
// MUL      | product held, down-counting to HI/LO update
// DIV_ITER | one restoring-divide step per clock
// DIV_FIX  | sign correction and HI/LO update
module fairy_muldiv_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_ITERS  = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    fairy_muldiv_ctrl_if.slave  bus
`ifdef MULDIV_BUSY_CNT_EN
    ,
    output logic [31:0]         busy_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL      = 2'd1,
        DIV_ITER = 2'd2,
        DIV_FIX  = 2'd3
    } state_t;

    localparam logic [4:0] MUL_LOAD = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] DIV_LOAD = 5'(DIV_ITERS - 1);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [63:0] prod_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [31:0] rs_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        dz_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic        accept;
    logic        commit_mul;
    logic        commit_div;
    logic        sgn;
    logic [31:0] rs_abs;
    logic [31:0] rt_abs;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_p;
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] rem_nx;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign accept = (state_q == IDLE) && bus.start_i && !bus.cancel_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Cancel takes priority over every completion path.
    always_comb begin
        state_d    = state_q;
        commit_mul = 1'b0;
        commit_div = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = bus.op_i[1] ? DIV_ITER : MUL;
                end
            end
            MUL: begin
                if (bus.cancel_i) begin
                    state_d = IDLE;
                end else if (cnt_q == 5'd0) begin
                    state_d    = IDLE;
                    commit_mul = 1'b1;
                end
            end
            DIV_ITER: begin
                if (bus.cancel_i) begin
                    state_d = IDLE;
                end else if (cnt_q == 5'd0) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                state_d = IDLE;
                if (!bus.cancel_i) begin
                    commit_div = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // op_i[0]=0 selects the signed variant for both multiply and divide.
    always_comb begin
        sgn    = ~bus.op_i[0];
        rs_abs = (sgn && bus.rs_i[31]) ? (~bus.rs_i + 32'd1) : bus.rs_i;
        rt_abs = (sgn && bus.rt_i[31]) ? (~bus.rt_i + 32'd1) : bus.rt_i;
        mul_a  = {{32{sgn & bus.rs_i[31]}}, bus.rs_i};
        mul_b  = {{32{sgn & bus.rt_i[31]}}, bus.rt_i};
        mul_p  = mul_a * mul_b;
    end

    // Remainder stays below the divisor, so a non-taken step never sets bit 32.
    always_comb begin
        rem_sh  = {rem_q, quo_q[31]};
        rem_ge  = (rem_sh >= {1'b0, dvs_q});
        rem_nx  = rem_ge ? 32'(rem_sh - {1'b0, dvs_q}) : rem_sh[31:0];
        quo_fix = q_neg_q ? (~quo_q + 32'd1) : quo_q;
        rem_fix = r_neg_q ? (~rem_q + 32'd1) : rem_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= 5'd0;
            prod_q  <= 64'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            rs_q    <= 32'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
        end else if (accept) begin
            rs_q <= bus.rs_i;
            if (bus.op_i[1]) begin
                rem_q   <= 32'd0;
                quo_q   <= rs_abs;
                dvs_q   <= rt_abs;
                q_neg_q <= sgn & (bus.rs_i[31] ^ bus.rt_i[31]);
                r_neg_q <= sgn & bus.rs_i[31];
                dz_q    <= (bus.rt_i == 32'd0);
                cnt_q   <= DIV_LOAD;
            end else begin
                prod_q <= mul_p;
                cnt_q  <= MUL_LOAD;
            end
        end else if (state_q == MUL) begin
            if (cnt_q != 5'd0) begin
                cnt_q <= cnt_q - 5'd1;
            end
        end else if (state_q == DIV_ITER) begin
            rem_q <= rem_nx;
            quo_q <= {quo_q[30:0], rem_ge};
            if (cnt_q != 5'd0) begin
                cnt_q <= cnt_q - 5'd1;
            end
        end
    end

    // MT writes only land in IDLE; commits only happen leaving a busy state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= commit_mul | commit_div;
            if (state_q == IDLE) begin
                if (bus.mthi_i) begin
                    hi_q <= bus.wdata_i;
                end
                if (bus.mtlo_i) begin
                    lo_q <= bus.wdata_i;
                end
            end
            if (commit_mul) begin
                hi_q <= prod_q[63:32];
                lo_q <= prod_q[31:0];
            end
            if (commit_div) begin
                if (dz_q) begin
                    hi_q <= rs_q;
                    lo_q <= 32'hFFFF_FFFF;
                end else begin
                    hi_q <= rem_fix;
                    lo_q <= quo_fix;
                end
            end
        end
    end

    assign bus.busy_o = (state_q != IDLE);
    assign bus.done_o = done_q;
    assign bus.hi_o   = hi_q;
    assign bus.lo_o   = lo_q;

`ifdef MULDIV_BUSY_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_cnt_o <= 32'd0;
        end else if ((state_q != IDLE) && (busy_cnt_o != 32'hFFFF_FFFF)) begin
            busy_cnt_o <= busy_cnt_o + 32'd1;
        end
    end
`endif

endmodule
